// File: rtl/quadrature_updown_decoder.sv
// Quadrature A/B decoder: synchronises the pins and emits a step/dir pair (counter
// t/mode style). It also keeps a wrapping position count and a sticky illegal-jump flag.
module quadrature_updown_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  input  logic             clr,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] qout,
  output logic             wrap,
  output logic             err
);

  logic [1:0] r_s1, r_s2, r_prev;
  logic [1:0] r_arm;

  logic       w_armed, w_act;
  logic [1:0] w_cur_pos, w_prev_pos, w_delta;
  logic       w_up, w_dn, w_bad;
  logic       w_wrap;

  // Map gray {a,b} to a 2-bit position so that a legal up step is +1 and a legal down step is -1.
  function automatic logic [1:0] gray2pos(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  always_comb begin
    w_armed    = (r_arm == 2'd3);
    w_act      = w_armed & en & ~clr;
    w_cur_pos  = gray2pos(r_s2);
    w_prev_pos = gray2pos(r_prev);
    w_delta    = w_cur_pos - w_prev_pos;
    w_up       = w_act & (w_delta == 2'd1);
    w_dn       = w_act & (w_delta == 2'd3);
    w_bad      = w_act & (w_delta == 2'd2);
    w_wrap     = (w_up & (qout == {WIDTH{1'b1}})) | (w_dn & (qout == {WIDTH{1'b0}}));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 2'b00;
      r_s2   <= 2'b00;
      r_prev <= 2'b00;
      r_arm  <= 2'd0;
      step   <= 1'b0;
      dir    <= 1'b0;
      qout   <= '0;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else begin
      r_s1   <= {a, b};
      r_s2   <= r_s1;
      r_prev <= r_s2;
      // Hold decode off until the sync chain and prev hold real pin values.
      if (!w_armed) r_arm <= r_arm + 2'd1;
      step <= w_up | w_dn;
      wrap <= w_wrap;
      if (w_up)      dir <= 1'b0;
      else if (w_dn) dir <= 1'b1;
      if (clr) begin
        qout <= '0;
        err  <= 1'b0;
      end else begin
        if (w_up)      qout <= qout + WIDTH'(1);
        else if (w_dn) qout <= qout - WIDTH'(1);
        if (w_bad) err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/quadrature_updown_decoder.md
Name: quadrature_updown_decoder

Overview:
- Front-end for the 4-bit up/down counter family: decodes a two-phase quadrature input (A/B) into a one-cycle count-step pulse and a direction flag.
- The step/direction pair matches the counter's t/mode convention (mode 0 = up, 1 = down).
- Also keeps its own WIDTH-bit position count with wrap detection and a sticky illegal-transition flag.
- Sits between the asynchronous encoder pins and any synchronous up/down counter or position consumer.

Parameters:
WIDTH, 4, width of internal position counter qout

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
a  input  1  quadrature phase A, asynchronous to clk
b  input  1  quadrature phase B, asynchronous to clk
en  input  1  decode enable; 0 = ignore transitions
clr  input  1  synchronous clear of qout and err
step  output  1  one-cycle pulse per legal transition (t-equivalent)
dir  output  1  direction of last legal step: 0 up, 1 down (mode-equivalent)
qout  output  WIDTH  position count
wrap  output  1  one-cycle pulse when qout wraps in either direction
err  output  1  sticky illegal-transition flag

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). On reset, all of the following go to 0 immediately: sync flops, prev state, arm counter, step, dir, qout, wrap, err.
- Synchronisation: a and b each pass through 2 flops (s1 → s2). prev is registered from s2 every cycle.
- Arming: decode is suppressed for the first 3 rising edges after rst_n deasserts. During arming, prev tracks s2 with no step and no err. This prevents spurious err when the pins sit at 11 at reset.
- Gray state is {a,b}.
  - Up sequence (A leads): 00→10→11→01→00. A legal up step sets dir=0.
  - Down sequence: reverse order. A legal down step sets dir=1.
- Decode compares s2 with prev each cycle:
  - Equal: no action.
  - One bit differs: legal step. step=1 for exactly one cycle, dir updated, qout incremented (up) or decremented (down).
  - Both bits differ: illegal. err set sticky; no step; qout and dir unchanged.
- Latency: a pin change stable before rising edge N produces step/qout/dir updates at edge N+2, i.e. step is high in the cycle after N+2.
- Arithmetic: qout is modulo 2^WIDTH.
  - Up from 2^WIDTH-1 gives 0 and wrap=1 for one cycle.
  - Down from 0 gives 2^WIDTH-1 and wrap=1.
  - wrap and step assert in the same cycle.
- dir holds its last value between steps. It is not cleared by clr.
- en=0: prev still tracks s2, but there is no step, no count and no err. Transitions that occur while disabled are lost. Re-enabling never causes a retroactive step.
- clr=1: at the next edge qout←0, err←0, step←0, wrap←0. clr has priority over a simultaneous legal step, which is dropped (prev still updates).
- Simultaneous illegal transition and clr: clr wins; err ends at 0.
- Reset mid-operation: everything returns to the reset state asynchronously, and arming restarts after release.
- Fastest input rate: one legal transition per 3 clocks guaranteed. Faster pin activity may alias into illegal transitions; this is not required to be handled.

Test Plan:
- Reset/arming: hold a=1,b=1 through reset, release → after arming step=0, err=0, qout=0.
- Up count (all tests: a/b change every 4 clocks, en=1): 8 legal transitions of the up sequence → 8 step pulses, dir=0, qout=8.
- Up wrap: 16 up transitions from 0 → qout=0; wrap pulses once, coincident with the 16th step.
- Down count: from qout=0, 3 down-sequence transitions → dir=1, qout=13; wrap pulses on the first step only.
- Illegal transition: jump from 00 to 11 → err=1, no step, qout unchanged. A following legal transition still counts. clr → qout=0, err=0, dir unchanged.
- Enable gating and clr priority:
  - en=0 during 4 transitions → qout unchanged, no step. Re-enable → the next transition counts exactly once.
  - clr asserted in the same cycle as a step → qout=0, step=0.
